// File: rtl/mc14500b_pkg.sv
// Shared constants for the MC14500B program sequencer: opcodes, default sizes
// and the layout of a program word ({opcode, operand}).
package mc14500b_pkg;

    localparam int PC_W_DEFAULT      = 8;
    localparam int STK_DEPTH_DEFAULT = 4;

    // Program word layout: opcode sits directly above the PC_W-wide operand.
    localparam int OPC_W    = 4;
    localparam int OPND_LSB = 0;

    typedef enum logic [3:0] {
        OP_NOPO = 4'h0,
        OP_LD   = 4'h1,
        OP_LDC  = 4'h2,
        OP_AND  = 4'h3,
        OP_ANDC = 4'h4,
        OP_OR   = 4'h5,
        OP_ORC  = 4'h6,
        OP_XNOR = 4'h7,
        OP_STO  = 4'h8,
        OP_STOC = 4'h9,
        OP_IEN  = 4'hA,
        OP_OEN  = 4'hB,
        OP_JMP  = 4'hC,
        OP_RTN  = 4'hD,
        OP_SKZ  = 4'hE,
        OP_NOPF = 4'hF
    } opcode_e;

endpackage

// File: rtl/mc14500b_ret_stack.sv
// Return-address LIFO for the sequencer. Overflowing pushes and underflowing
// pops leave the contents untouched and are only reported.
module mc14500b_ret_stack
    import mc14500b_pkg::*;
#(
    parameter int W     = PC_W_DEFAULT,
    parameter int DEPTH = STK_DEPTH_DEFAULT
) (
    input  logic         clk_in,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top_data,
    output logic [2:0]   depth,
    output logic         overflow,
    output logic         underflow
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic [2:0]   depth_q;
    logic [2:0]   depth_d;
    logic         full;
    logic         empty;

    assign full      = (depth_q == 3'(DEPTH));
    assign empty     = (depth_q == 3'd0);
    assign overflow  = push & full;
    assign underflow = pop & empty;
    assign depth     = depth_q;

    always_comb begin
        mem_d   = mem_q;
        depth_d = depth_q;
        if (pop && !empty) begin
            depth_d = depth_q - 3'd1;
        end else if (push && !full) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (depth_q == 3'(i)) begin
                    mem_d[i] = push_data;
                end
            end
            depth_d = depth_q + 3'd1;
        end
    end

    always_comb begin
        top_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (depth_q == 3'(i + 1)) begin
                top_data = mem_q[i];
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            depth_q <= 3'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            depth_q <= depth_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: rtl/mc14500b_sequencer.sv
// Program counter, operand latch and call/return stack wrapped around an
// MC14500B ICU. Only fetch edges (state_in low) change any state.
module mc14500b_sequencer
    import mc14500b_pkg::*;
#(
    parameter int PC_W      = PC_W_DEFAULT,
    parameter int STK_DEPTH = STK_DEPTH_DEFAULT
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic                  state_in,
    input  logic                  JMP,
    input  logic                  RTN,
    input  logic                  FLGF,
    output logic [PC_W-1:0]       prog_addr,
    input  logic [PC_W+OPC_W-1:0] prog_data,
    output logic [OPC_W-1:0]      I,
    output logic [PC_W-1:0]       io_addr,
    output logic [2:0]            stk_depth,
    output logic                  stk_err
);

    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] opnd_q, opnd_d;
    logic            err_q, err_d;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] stk_top;
    logic            fetch;
    logic            push;
    logic            pop;
    logic            overflow;
    logic            underflow;

    assign fetch  = ~state_in;
    assign pc_inc = pc_q + PC_W'(1);
    // RTN outranks JMP, which outranks the NOPF call.
    assign pop    = fetch & RTN;
    assign push   = fetch & FLGF & ~JMP & ~RTN;

    mc14500b_ret_stack #(
        .W     (PC_W),
        .DEPTH (STK_DEPTH)
    ) u_stack (
        .clk_in    (clk_in),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top_data  (stk_top),
        .depth     (stk_depth),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always_comb begin
        pc_d   = pc_q;
        opnd_d = opnd_q;
        err_d  = err_q;
        if (fetch) begin
            opnd_d = prog_data[OPND_LSB +: PC_W];
            if (RTN) begin
                pc_d = underflow ? pc_inc : stk_top;
            end else if (JMP || FLGF) begin
                pc_d = opnd_q;
            end else begin
                pc_d = pc_inc;
            end
            if (overflow || underflow) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            pc_q   <= '0;
            opnd_q <= '0;
            err_q  <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            opnd_q <= opnd_d;
            err_q  <= err_d;
        end
    end

    assign prog_addr = pc_q;
    assign io_addr   = opnd_q;
    assign I         = prog_data[PC_W +: OPC_W];
    assign stk_err   = err_q;

endmodule

// File: doc/mc14500b_sequencer.md
MC14500B_SEQUENCER -- requirements
Module: mc14500b_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 8, program counter and operand width.
REQ-002 SHALL have parameter STK_DEPTH, default 4, return-stack entries.
REQ-003 SHALL have port clk_in, input, 1, the single clock, shared with the ICU.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port state_in, input, 1, ICU state_out (0 = FETCH cycle, 1 = DECODE_EXECUTE cycle).
REQ-006 SHALL have ports JMP, RTN and FLGF, input, 1 each, ICU flag outputs.
REQ-007 SHALL have port prog_addr, output, PC_W, program memory address, equal to PC.
REQ-008 SHALL have port prog_data, input, 4+PC_W, program word: [PC_W+3:PC_W] opcode, [PC_W-1:0] operand.
REQ-009 SHALL have port I, output, 4, opcode to the ICU, combinationally equal to prog_data[PC_W+3:PC_W].
REQ-010 SHALL have port io_addr, output, PC_W, I/O select address, equal to the operand register.
REQ-011 SHALL have port stk_depth, output, 3, current return-stack occupancy.
REQ-012 SHALL have port stk_err, output, 1, sticky stack overflow/underflow flag.

Function
REQ-013 SHALL update state only on posedge clk_in with state_in==0 (fetch edge); SHALL hold all registers at edges with state_in==1.
REQ-014 At each fetch edge the operand register SHALL load prog_data[PC_W-1:0], so io_addr stays stable for the whole DECODE_EXECUTE cycle and the following FETCH cycle, covering the ICU write pulse.
REQ-015 At a fetch edge with JMP, RTN and FLGF all low, PC SHALL become PC+1 modulo 2^PC_W (0xFF wraps to 0x00).
REQ-016 At a fetch edge with JMP high, PC SHALL load the operand register value, which is the JMP operand; the word fetched in that cycle executes as a delay slot.
REQ-017 At a fetch edge with FLGF high and JMP low (call via NOPF), PC+1 SHALL be pushed and PC SHALL load the operand register value; the delay slot executes and return resumes after it.
REQ-018 At a fetch edge with RTN high, PC SHALL load the popped top of stack; the ICU skips the word fetched in that cycle.
REQ-019 Priority SHALL be RTN > JMP > FLGF when flags are simultaneous.
REQ-020 A push while stk_depth==STK_DEPTH SHALL leave the stack unchanged, still load the target, and set stk_err.
REQ-021 A pop while stk_depth==0 SHALL set stk_err and advance PC as in REQ-015.
REQ-022 stk_err SHALL clear only on reset.
REQ-023 The sequencer SHALL NOT interpret opcodes; SKZ and IEN/OEN effects remain entirely in the ICU.

Reset
REQ-024 When rst is low, the block SHALL asynchronously set PC=0, operand register=0, stk_depth=0, stk_err=0, and all stack entries=0.
REQ-025 Reset asserted mid-call or mid-jump SHALL discard pending targets; the first fetch after release SHALL be from address 0.

Structure
REQ-026 Package mc14500b_pkg SHALL hold the opcode constants (NOPO..NOPF), PC_W and STK_DEPTH defaults, and the program word field positions.
REQ-027 The LIFO SHALL be sub-module mc14500b_ret_stack with push/pop/data/depth/overflow/underflow ports, reset like the parent.

Verification
REQ-028 Reset, then straight-line code with the ICU in loop: prog_addr sequence 0,0,1,1,2,2...; io_addr equals the previous word's operand from the fetch edge onward.
REQ-029 Word at 0x05 is JMP 0x40: 0x06 is fetched and executed as the delay slot, then prog_addr=0x40.
REQ-030 NOPF 0x80 at 0x10, RTN at 0x82: execution is 0x11, 0x80, 0x81, 0x82, then 0x83 skipped, then resumes at 0x12; stk_depth goes 0, 1, 0.
REQ-031 Five nested calls with STK_DEPTH=4: fifth sets stk_err=1, depth stays 4, jump taken; RTN at depth 0 sets stk_err and PC advances.
REQ-032 PC=0xFF with no flags: next prog_addr=0x00.
REQ-033 rst low during a JMP delay-slot FETCH cycle: PC=0 immediately, target lost, stk_err=0.
